// File: rtl/conv_pkg.sv
// Shared rate-1/2 convolutional code definitions: FSM states, default code
// parameters and the codeword function, used by both encoder and decoder.
package conv_pkg;

    localparam int K_MAX  = 9;
    localparam int CONV_K = 3;
    localparam logic [CONV_K-1:0] CONV_G0 = 3'b111;
    localparam logic [CONV_K-1:0] CONV_G1 = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        TAIL
    } conv_state_t;

    // v and the generators are right-aligned (zero-extended) to K_MAX bits.
    function automatic logic [1:0] conv_codeword(
        input logic [K_MAX-1:0] v,
        input logic [K_MAX-1:0] g0,
        input logic [K_MAX-1:0] g1
    );
        return {^(v & g1), ^(v & g0)};
    endfunction

endpackage

// File: rtl/conv_encoder_if.sv
// Stream bundle between the encoder and its neighbours: serial information
// bits in, (cx1,cx0) symbols with keep mask and frame-end marker out.
interface conv_encoder_if;

    logic       in_valid;
    logic       in_ready;
    logic       in_bit;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic       cx0;
    logic       cx1;
    logic       out_last;
    logic [1:0] out_mask;

    modport slave (
        input  in_valid, in_bit, in_last, out_ready,
        output in_ready, out_valid, cx0, cx1, out_last, out_mask
    );

    modport master (
        output in_valid, in_bit, in_last, out_ready,
        input  in_ready, out_valid, cx0, cx1, out_last, out_mask
    );

endinterface

// File: rtl/conv_enc_shreg.sv
// Encoder history register plus combinational codeword for the bit currently
// presented; history advances only when a symbol is actually generated.
module conv_enc_shreg
    import conv_pkg::*;
#(
    parameter int           K  = CONV_K,
    parameter logic [K-1:0] G0 = CONV_G0,
    parameter logic [K-1:0] G1 = CONV_G1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_adv,
    input  logic       i_bit,
    output logic [1:0] o_sym
);

    logic [K-2:0] r_sr;
    logic [K-1:0] w_v;

    // Generator MSB taps the current bit and each lower generator bit taps
    // one step further back in time, so the newest history bit sits just
    // below the current bit.
    assign w_v[K-1] = i_bit;
    generate
        for (genvar gi = 0; gi < K - 1; gi++) begin : g_tap
            assign w_v[K-2-gi] = r_sr[gi];
        end
    endgenerate

    assign o_sym = conv_codeword(K_MAX'(w_v), K_MAX'(G0), K_MAX'(G1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sr <= '0;
        end else if (i_adv) begin
            r_sr <= {r_sr[K-3:0], i_bit};
        end
    end

endmodule

// File: rtl/conv_encoder.sv
// Rate-1/2 framed convolutional encoder with zero-tail termination.
// Optional rate-2/3 puncturing of information symbols with `define PUNCT_EN.
module conv_encoder
    import conv_pkg::*;
#(
    parameter int           K  = CONV_K,
    parameter logic [K-1:0] G0 = CONV_G0,
    parameter logic [K-1:0] G1 = CONV_G1
) (
    input  logic           clk,
    input  logic           reset,
    conv_encoder_if.slave  bus
);

    localparam int            CW       = $clog2(K) + 1;
    localparam logic [CW-1:0] TAIL_LEN = CW'(K - 1);

    conv_state_t   r_state;
    conv_state_t   w_state_next;
    logic [CW-1:0] r_tail_cnt;
    logic [CW-1:0] w_tail_cnt_next;

    logic       r_out_valid;
    logic       r_cx0;
    logic       r_cx1;
    logic       r_out_last;
    logic [1:0] r_out_mask;

    logic       w_adv;
    logic       w_in_ready;
    logic       w_accept;
    logic       w_gen;
    logic       w_bit;
    logic       w_last;
    logic [1:0] w_mask;
    logic [1:0] w_sym;

    assign w_adv = !r_out_valid || bus.out_ready;

    conv_enc_shreg #(
        .K  (K),
        .G0 (G0),
        .G1 (G1)
    ) u_shreg (
        .clk   (clk),
        .reset (reset),
        .i_adv (w_gen),
        .i_bit (w_bit),
        .o_sym (w_sym)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_tail_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_tail_cnt <= w_tail_cnt_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_tail_cnt_next = r_tail_cnt;
        w_in_ready      = 1'b0;
        w_accept        = 1'b0;
        w_gen           = 1'b0;
        w_bit           = 1'b0;
        w_last          = 1'b0;
        case (r_state)
            IDLE, DATA: begin
                w_in_ready = w_adv && !reset;
                w_accept   = w_in_ready && bus.in_valid;
                w_gen      = w_accept;
                w_bit      = bus.in_bit;
                if (w_accept) begin
                    if (bus.in_last) begin
                        w_state_next    = TAIL;
                        w_tail_cnt_next = TAIL_LEN;
                    end else begin
                        w_state_next = DATA;
                    end
                end
            end
            TAIL: begin
                // Tail symbols flush zeros; the final one lands the history at 0.
                w_gen = w_adv;
                if (w_adv) begin
                    w_tail_cnt_next = r_tail_cnt - 1'b1;
                    if (r_tail_cnt == CW'(1)) begin
                        w_last       = 1'b1;
                        w_state_next = IDLE;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

`ifdef PUNCT_EN
    logic r_idx_odd;
    logic w_idx_odd;

    // The first information bit of a frame is always accepted from IDLE,
    // which restarts the index parity at even.
    assign w_idx_odd = (r_state == IDLE) ? 1'b0 : r_idx_odd;
    assign w_mask    = (r_state != TAIL && w_idx_odd) ? 2'b01 : 2'b11;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx_odd <= 1'b0;
        end else if (w_accept) begin
            r_idx_odd <= !w_idx_odd;
        end
    end
`else
    assign w_mask = 2'b11;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_cx0       <= 1'b0;
            r_cx1       <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_mask  <= 2'b11;
        end else if (w_gen) begin
            r_out_valid <= 1'b1;
            r_cx0       <= w_sym[0];
            r_cx1       <= w_sym[1] & w_mask[1];
            r_out_last  <= w_last;
            r_out_mask  <= w_mask;
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.cx0       = r_cx0;
    assign bus.cx1       = r_cx1;
    assign bus.out_last  = r_out_last;
    assign bus.out_mask  = r_out_mask;

endmodule

// File: tb/tb_conv_encoder.sv
// Self-checking bench for conv_encoder: table vectors, directed corner cases
// and randomized frames against a history-based reference model.
module tb_conv_encoder;
    import conv_pkg::*;

    localparam int         TK  = 3;
    localparam logic [2:0] TG0 = 3'b111;
    localparam logic [2:0] TG1 = 3'b101;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   rdy_mode = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    logic [4:0] obs_q[$];
    logic [4:0] exp_q[$];
    int         hs_q[$];

    conv_encoder_if cif();

    conv_encoder #(
        .K  (TK),
        .G0 (TG0),
        .G1 (TG1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (cif)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Downstream ready generator: 0 always ready, 1 pattern 1,0,0, 2 random.
    initial begin
        int rp = 0;
        cif.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1: begin
                    cif.out_ready = (rp % 3 == 0);
                    rp++;
                end
                2: cif.out_ready = ($urandom_range(3) != 0);
                default: cif.out_ready = 1'b1;
            endcase
        end
    end

    // Output monitor: records handshakes and checks hold/ready rules.
    logic       prev_stall = 1'b0;
    logic [5:0] prev_out = '0;
    always @(negedge clk) begin
        if (reset) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall)
                chk("hold", 32'({cif.out_valid, cif.out_last, cif.out_mask, cif.cx1, cif.cx0}),
                    32'(prev_out));
            if (cif.out_valid && !cif.out_ready)
                chk("in_ready_stall", 32'(cif.in_ready), 32'(0));
            if (cif.out_valid && cif.out_ready) begin
                obs_q.push_back({cif.out_last, cif.out_mask, cif.cx1, cif.cx0});
                hs_q.push_back(cyc);
            end
            prev_stall <= cif.out_valid && !cif.out_ready;
            prev_out   <= {cif.out_valid, cif.out_last, cif.out_mask, cif.cx1, cif.cx0};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        obs_q.delete();
        hs_q.delete();
        exp_q.delete();
    endtask

    // Reference: each code bit is the XOR of the generator-selected bits of
    // the last K inputs (current first), the frame padded with K-1 zeros.
    task automatic model_frame(input bit bits[$]);
        bit         hist[$];
        int         n;
        bit         b;
        bit         h;
        bit         c0;
        bit         c1;
        logic [1:0] m;
        n = bits.size();
        for (int t = 0; t < n + TK - 1; t++) begin
            b = (t < n) ? bits[t] : 1'b0;
            hist.push_front(b);
            c0 = 1'b0;
            c1 = 1'b0;
            for (int j = 0; j < TK; j++) begin
                h = (j < hist.size()) ? hist[j] : 1'b0;
                c0 ^= TG0[TK-1-j] & h;
                c1 ^= TG1[TK-1-j] & h;
            end
            m = 2'b11;
`ifdef PUNCT_EN
            if (t < n && (t % 2) == 1) begin
                m  = 2'b01;
                c1 = 1'b0;
            end
`endif
            exp_q.push_back({(t == n + TK - 2), m, c1, c0});
        end
    endtask

    // Presents each bit with in_valid held; leaves in_valid asserted.
    task automatic send_bits(input bit bits[$]);
        for (int i = 0; i < bits.size(); i++) begin
            int guard;
            bit acc;
            guard = 0;
            acc = 1'b0;
            cif.in_valid = 1'b1;
            cif.in_bit   = bits[i];
            cif.in_last  = (i == bits.size() - 1);
            while (!acc && guard < 500) begin
                @(negedge clk);
                acc = cif.in_ready;
                @(posedge clk);
                #1;
                guard++;
            end
            chk("accept", 32'(acc), 32'(1));
            if (!acc) return;
        end
    endtask

    task automatic wait_and_compare(input string name, input bit gap_check);
        int guard;
        guard = 0;
        while (obs_q.size() < exp_q.size() && guard < 2000) begin
            tick();
            guard++;
        end
        repeat (6) tick();
        chk({name, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            chk(name, 32'(obs_q[i]), 32'(exp_q[i]));
        if (gap_check && hs_q.size() > 0)
            chk({name, "_gap"}, 32'(hs_q[hs_q.size()-1] - hs_q[0]), 32'(exp_q.size() - 1));
    endtask

    typedef struct {
        int          n;
        logic [7:0]  bits;   // bit i = i-th information bit
        logic [15:0] syms;   // [2i+1:2i] = {cx1,cx0} of symbol i
        int          rmode;
    } vec_t;

    initial begin
        vec_t       vecs[3];
        bit         fr[$];
        logic [1:0] s;
        logic [1:0] m;
        int         nf;

        vecs[0] = '{4, 8'b0000_1101, 16'h0E87, 0};
        vecs[1] = '{1, 8'b0000_0001, 16'h0037, 0};
        vecs[2] = '{4, 8'b0000_1101, 16'h0E87, 1};

        cif.in_valid = 1'b0;
        cif.in_bit   = 1'b0;
        cif.in_last  = 1'b0;

        // Reset state
        reset = 1'b1;
        tick();
        @(negedge clk);
        chk("rst_in_ready", 32'(cif.in_ready), 32'(0));
        tick();
        @(negedge clk);
        chk("rst_out_valid", 32'(cif.out_valid), 32'(0));
        chk("rst_out_last", 32'(cif.out_last), 32'(0));
        chk("rst_cx", 32'({cif.cx1, cif.cx0}), 32'(0));
        chk("rst_mask", 32'(cif.out_mask), 32'(2'b11));
        tick();
        reset = 1'b0;
        tick();

        // Table vectors
        for (int v = 0; v < 3; v++) begin
            rdy_mode = vecs[v].rmode;
            clear_obs();
            fr.delete();
            for (int i = 0; i < vecs[v].n; i++) fr.push_back(vecs[v].bits[i]);
            for (int i = 0; i < vecs[v].n + TK - 1; i++) begin
                s = vecs[v].syms[2*i +: 2];
                m = 2'b11;
`ifdef PUNCT_EN
                if (i < vecs[v].n && (i % 2) == 1) begin
                    m    = 2'b01;
                    s[1] = 1'b0;
                end
`endif
                exp_q.push_back({(i == vecs[v].n + TK - 2), m, s});
            end
            send_bits(fr);
            cif.in_valid = 1'b0;
            wait_and_compare("vec", vecs[v].rmode == 0);
            rdy_mode = 0;
            repeat (3) tick();
        end

        // in_ready low through the tail, next frame accepted as out_last leaves
        clear_obs();
        fr = {1'b1, 1'b0, 1'b1, 1'b1};
        model_frame(fr);
        fr = {1'b1};
        model_frame(fr);
        for (int i = 0; i < 4; i++) begin
            cif.in_valid = 1'b1;
            cif.in_bit   = (i != 1);
            cif.in_last  = (i == 3);
            @(negedge clk);
            chk("ready_data", 32'(cif.in_ready), 32'(1));
            tick();
        end
        cif.in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("ready_tail", 32'(cif.in_ready), 32'(0));
            chk("last_early", 32'(cif.out_last), 32'(0));
            tick();
        end
        cif.in_valid = 1'b1;
        cif.in_bit   = 1'b1;
        cif.in_last  = 1'b1;
        @(negedge clk);
        chk("ready_after_tail", 32'(cif.in_ready), 32'(1));
        chk("last_on_tail", 32'(cif.out_last), 32'(1));
        tick();
        cif.in_valid = 1'b0;
        wait_and_compare("tail_next", 1'b1);

        // Reset after two accepted bits abandons the frame
        clear_obs();
        cif.in_valid = 1'b1;
        cif.in_last  = 1'b0;
        cif.in_bit   = 1'b1;
        tick();
        cif.in_bit   = 1'b0;
        tick();
        cif.in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", 32'(cif.in_ready), 32'(0));
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", 32'(cif.out_valid), 32'(0));
        chk("midrst_sr", 32'(dut.u_shreg.r_sr), 32'(0));
        chk("midrst_state", 32'(dut.r_state), 32'(IDLE));
        tick();
        clear_obs();
        fr = {1'b1, 1'b0, 1'b1, 1'b1};
        model_frame(fr);
        send_bits(fr);
        cif.in_valid = 1'b0;
        wait_and_compare("after_rst", 1'b1);

        // Back-to-back random frames, in_valid held throughout
        clear_obs();
        for (int f = 0; f < 3; f++) begin
            fr.delete();
            nf = $urandom_range(8, 1);
            for (int i = 0; i < nf; i++) fr.push_back(1'($urandom_range(1)));
            model_frame(fr);
            send_bits(fr);
        end
        cif.in_valid = 1'b0;
        wait_and_compare("b2b", 1'b1);

        // Random frames, random backpressure and input gaps
        rdy_mode = 2;
        clear_obs();
        for (int f = 0; f < 20; f++) begin
            fr.delete();
            nf = $urandom_range(8, 1);
            for (int i = 0; i < nf; i++) fr.push_back(1'($urandom_range(1)));
            model_frame(fr);
            send_bits(fr);
            if ($urandom_range(1) == 1) begin
                cif.in_valid = 1'b0;
                repeat ($urandom_range(3, 1)) tick();
            end
        end
        cif.in_valid = 1'b0;
        wait_and_compare("rand", 1'b0);
        rdy_mode = 0;
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
